// File: rtl/adda_stream_proc.sv
// A/D -> D/A sample path: input register, sample-rate divider, four output modes
// (loopback, boxcar average, ramp, hold), peak tracking and a sticky over-range flag.
module adda_stream_proc #(
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int DIV_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_ad_data,
  input  logic [1:0]        i_mode,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [DATA_W-1:0] i_step,
  input  logic              i_peak_clr,
  output logic [DATA_W-1:0] o_da_data,
  output logic              o_da_valid,
  output logic [DATA_W-1:0] o_peak,
  output logic              o_overrange,
  output logic [7:0]        o_led
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] MODE_LOOP = 2'd0;
  localparam logic [1:0] MODE_AVG  = 2'd1;
  localparam logic [1:0] MODE_RAMP = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  logic [DATA_W-1:0] ad_q, ad_d;
  logic [DIV_W-1:0]  div_ctr_q, div_ctr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  avg_cnt_q, avg_cnt_d;
  logic [DATA_W-1:0] da_data_q, da_data_d;
  logic              da_valid_q, da_valid_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic              overrange_q, overrange_d;

  logic              strobe;
  logic              sample_extreme;
  logic [ACC_W-1:0]  acc_sum;

  always_comb begin
    ad_d           = i_ad_data;
    // ">=" lets a lowered i_div take effect at once instead of wrapping the counter.
    strobe         = (div_ctr_q >= i_div);
    div_ctr_d      = strobe ? '0 : div_ctr_q + DIV_W'(1);
    sample_extreme = (ad_q == '0) || (ad_q == '1);
    acc_sum        = acc_q + ACC_W'(ad_q);

    da_data_d   = da_data_q;
    da_valid_d  = 1'b0;
    acc_d       = acc_q;
    avg_cnt_d   = avg_cnt_q;
    peak_d      = peak_q;
    overrange_d = overrange_q;

    // Any clock outside average mode discards the partial window.
    if (i_mode != MODE_AVG) begin
      acc_d     = '0;
      avg_cnt_d = '0;
    end

    if (strobe) begin
      case (i_mode)
        MODE_LOOP: begin
          da_data_d  = ad_q;
          da_valid_d = 1'b1;
        end
        MODE_AVG: begin
          if (avg_cnt_q == AVG_LAST) begin
            da_data_d  = DATA_W'(acc_sum >> AVG_LOG2);
            da_valid_d = 1'b1;
            acc_d      = '0;
            avg_cnt_d  = '0;
          end else begin
            acc_d     = acc_sum;
            avg_cnt_d = avg_cnt_q + CNT_W'(1);
          end
        end
        MODE_RAMP: begin
          da_data_d  = da_data_q + i_step;
          da_valid_d = 1'b1;
        end
        MODE_HOLD: begin
          da_data_d = da_data_q;
        end
        default: begin
          da_data_d = da_data_q;
        end
      endcase
    end

    // A clear coinciding with a strobe restarts tracking from that sample.
    if (i_peak_clr && strobe) begin
      peak_d      = ad_q;
      overrange_d = sample_extreme;
    end else if (i_peak_clr) begin
      peak_d      = '0;
      overrange_d = 1'b0;
    end else if (strobe) begin
      if (ad_q > peak_q) peak_d = ad_q;
      if (sample_extreme) overrange_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ad_q        <= '0;
      div_ctr_q   <= '0;
      acc_q       <= '0;
      avg_cnt_q   <= '0;
      da_data_q   <= '0;
      da_valid_q  <= 1'b0;
      peak_q      <= '0;
      overrange_q <= 1'b0;
    end else begin
      ad_q        <= ad_d;
      div_ctr_q   <= div_ctr_d;
      acc_q       <= acc_d;
      avg_cnt_q   <= avg_cnt_d;
      da_data_q   <= da_data_d;
      da_valid_q  <= da_valid_d;
      peak_q      <= peak_d;
      overrange_q <= overrange_d;
    end
  end

  // o_da_valid is a one-cycle qualifier with no back-pressure: the DAC side
  // must take o_da_data on the cycle o_da_valid is high.
  assign o_da_data   = da_data_q;
  assign o_da_valid  = da_valid_q;
  assign o_peak      = peak_q;
  assign o_overrange = overrange_q;

  generate
    if (DATA_W >= 8) begin : g_led_msb
      assign o_led = da_data_q[DATA_W-1 -: 8];
    end else begin : g_led_pad
      assign o_led = {{(8 - DATA_W){1'b0}}, da_data_q};
    end
  endgenerate

endmodule

// File: tb/tb_adda_stream_proc.sv
// Directed bench for adda_stream_proc (DATA_W=8, AVG_LOG2=2, DIV_W=8).
module tb_adda_stream_proc;

  logic       clk;
  logic       rst_n;
  logic [7:0] ad_data;
  logic [1:0] mode;
  logic [7:0] div;
  logic [7:0] step;
  logic       peak_clr;
  logic [7:0] da_data;
  logic       da_valid;
  logic [7:0] peak;
  logic       overrange;
  logic [7:0] led;

  int n_checks = 0;
  int n_errors = 0;

  adda_stream_proc #(.DATA_W(8), .AVG_LOG2(2), .DIV_W(8)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_ad_data   (ad_data),
    .i_mode      (mode),
    .i_div       (div),
    .i_step      (step),
    .i_peak_clr  (peak_clr),
    .o_da_data   (da_data),
    .o_da_valid  (da_valid),
    .o_peak      (peak),
    .o_overrange (overrange),
    .o_led       (led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] avg_vals [10];
  logic [7:0] ramp_exp [5];
  logic [7:0] pk_ad    [8];
  logic       pk_clr   [8];
  logic [7:0] pk_div   [8];
  logic [7:0] pk_peak  [8];
  logic       pk_ovr   [8];

  initial begin
    rst_n = 1'b0; ad_data = '0; mode = 2'd0; div = '0; step = '0; peak_clr = 1'b0;
    #3;
    check_eq("reset_data", da_data, 0);
    check_eq("reset_valid", da_valid, 0);
    check_eq("reset_peak", peak, 0);
    check_eq("reset_ovr", overrange, 0);
    check_eq("reset_led", led, 0);

    // Test 1: loopback, two-cycle latency, valid every clock
    do_reset();
    for (int k = 0; k < 256; k++) begin
      ad_data = 8'(k);
      tick();
      check_eq("loop_data", da_data, (k == 0) ? 0 : k - 1);
      check_eq("loop_valid", da_valid, 1);
    end
    tick();
    check_eq("loop_last", da_data, 8'hFF);
    check_eq("loop_led", led, 8'hFF);
    check_eq("loop_peak", peak, 8'hFF);
    check_eq("loop_ovr", overrange, 1);

    // Test 3: ramp from 0 with wrap
    ad_data = 8'h00;
    tick();
    tick();
    check_eq("ramp_start", da_data, 0);
    ramp_exp = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
    mode = 2'd2;
    step = 8'h40;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("ramp_data", da_data, ramp_exp[k]);
      check_eq("ramp_valid", da_valid, 1);
    end

    // Test 4: hold after loopback 0x5A
    mode = 2'd0;
    ad_data = 8'h5A;
    tick();
    tick();
    check_eq("hold_pre", da_data, 8'h5A);
    mode = 2'd3;
    ad_data = 8'h11;
    for (int k = 0; k < 100; k++) begin
      tick();
      check_eq("hold_data", da_data, 8'h5A);
      check_eq("hold_valid", da_valid, 0);
    end

    // Test 2: average, i_div=3, window restart on mode change
    avg_vals = '{8'd10, 8'd20, 8'd30, 8'd41, 8'd100, 8'd100, 8'd4, 8'd8, 8'd12, 8'd16};
    mode = 2'd1;
    div = 8'd3;
    ad_data = avg_vals[0];
    do_reset();
    for (int e = 0; e < 40; e++) begin
      ad_data = avg_vals[e / 4];
      mode = (e == 24) ? 2'd0 : 2'd1;
      tick();
      check_eq("avg_valid", da_valid, (e == 15 || e == 39) ? 1 : 0);
      check_eq("avg_data", da_data, (e < 15) ? 0 : (e < 39) ? 25 : 10);
    end
    check_eq("avg_peak", peak, 100);
    check_eq("avg_ovr", overrange, 0);

    // Test 5: peak tracking and clears
    pk_ad   = '{8'h30, 8'h90, 8'h50, 8'h20, 8'hFF, 8'h77, 8'h77, 8'h77};
    pk_clr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    pk_div  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    pk_peak = '{8'h00, 8'h30, 8'h90, 8'h90, 8'h20, 8'hFF, 8'h00, 8'h77};
    pk_ovr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    mode = 2'd0;
    div = 8'd0;
    peak_clr = 1'b0;
    ad_data = pk_ad[0];
    do_reset();
    for (int e = 0; e < 8; e++) begin
      ad_data = pk_ad[e];
      peak_clr = pk_clr[e];
      div = pk_div[e];
      tick();
      check_eq("peak_val", peak, pk_peak[e]);
      check_eq("peak_ovr", overrange, pk_ovr[e]);
    end
    check_eq("peak_final_data", da_data, 8'h77);
    check_eq("peak_final_valid", da_valid, 1);
    peak_clr = 1'b0;

    // Test 6: asynchronous reset mid-average
    mode = 2'd1;
    div = 8'd3;
    ad_data = 8'd200;
    do_reset();
    for (int e = 0; e < 21; e++) tick();
    check_eq("pre_rst_data", da_data, 200);
    check_eq("pre_rst_peak", peak, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_data", da_data, 0);
    check_eq("async_valid", da_valid, 0);
    check_eq("async_peak", peak, 0);
    check_eq("async_ovr", overrange, 0);
    check_eq("async_led", led, 0);
    tick();
    ad_data = 8'd8;
    rst_n = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (e == 2) check_eq("first_strobe_pre", peak, 0);
      if (e == 3) check_eq("first_strobe", peak, 8);
      check_eq("rst_avg_valid", da_valid, (e == 15) ? 1 : 0);
      check_eq("rst_avg_data", da_data, (e == 15) ? 8 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
